bomb_controller: RTL and testbench

Producer side of the explosion interface that the player module consumes. On a centre-button press it places a single bomb, snapped to the 16-pixel tile grid under the player, and runs a fuse timer. When the fuse expires it emits a one-cycle explosion_SCEN pulse with stable e_x/e_y. It then holds a plus-shaped explosion visible for a fixed time, and drives bomb_on/explosion_on pixel flags to the top-level VGA mux.

---
 rtl/bomb_controller_pkg.sv | 27 ++
 rtl/bomb_controller_if.sv | 28 ++
 rtl/bomb_controller_explosion_shape.sv | 27 ++
 rtl/bomb_controller.sv | 85 ++++++++
 tb/tb_bomb_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bomb_controller_pkg.sv
// Shared types and constants for the bomb controller and its consumers (player hit test,
// block destruction). Keeping the blast geometry here makes every user agree on one shape.
package bomb_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        EXPLODE = 2'b10
    } state_t;

    localparam int COORD_W   = 10;
    localparam int TILE      = 16;
    localparam int E_ARM_NEG = 48;
    localparam int E_ARM_POS = 63;
    localparam int E_WIDTH   = 16;
    localparam int PF_MIN_X  = 143;
    localparam int PF_MIN_Y  = 34;

    // Snap a sprite top-left coordinate to the tile under the sprite centre.
    function automatic logic [COORD_W-1:0] snap(input logic [COORD_W-1:0] pos,
                                                input logic [COORD_W-1:0] min_edge);
        logic [COORD_W-1:0] off;
        off = pos + COORD_W'(TILE / 2) - min_edge;
        return min_edge + {off[COORD_W-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/bomb_controller_if.sv
// Explosion interface between the bomb controller (slave side) and the player/top level.
interface bomb_controller_if;
    import bomb_controller_pkg::*;

    logic               C;
    logic [COORD_W-1:0] b_x;
    logic [COORD_W-1:0] b_y;
    logic               game_over;
    logic [COORD_W-1:0] v_x;
    logic [COORD_W-1:0] v_y;
    logic [COORD_W-1:0] e_x;
    logic [COORD_W-1:0] e_y;
    logic               explosion_SCEN;
    logic               bomb_active;
    logic               bomb_on;
    logic               explosion_on;

    modport master (
        output C, b_x, b_y, game_over, v_x, v_y,
        input  e_x, e_y, explosion_SCEN, bomb_active, bomb_on, explosion_on
    );

    modport slave (
        input  C, b_x, b_y, game_over, v_x, v_y,
        output e_x, e_y, explosion_SCEN, bomb_active, bomb_on, explosion_on
    );

endinterface

// File: rtl/bomb_controller_explosion_shape.sv
// Combinational pixel-in-plus test around a blast tile; shared with block destruction.
module explosion_shape
    import bomb_controller_pkg::*;
(
    input  logic [COORD_W-1:0] v_x,
    input  logic [COORD_W-1:0] v_y,
    input  logic [COORD_W-1:0] e_x,
    input  logic [COORD_W-1:0] e_y,
    output logic               hit
);
    logic [COORD_W:0] vx, vy, ex, ey;
    logic in_row, in_col, reach_x, reach_y;

    assign vx = {1'b0, v_x};
    assign vy = {1'b0, v_y};
    assign ex = {1'b0, e_x};
    assign ey = {1'b0, e_y};

    // Left/up arms compare v+48 >= e so a tile at the playfield edge never underflows.
    assign in_row  = (vy >= ey) && (vy <= ey + (COORD_W+1)'(E_WIDTH - 1));
    assign in_col  = (vx >= ex) && (vx <= ex + (COORD_W+1)'(E_WIDTH - 1));
    assign reach_x = (vx + (COORD_W+1)'(E_ARM_NEG) >= ex) && (vx <= ex + (COORD_W+1)'(E_ARM_POS));
    assign reach_y = (vy + (COORD_W+1)'(E_ARM_NEG) >= ey) && (vy <= ey + (COORD_W+1)'(E_ARM_POS));

    assign hit = (in_row && reach_x) || (in_col && reach_y);

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb controller: places a grid-snapped bomb on a button edge, runs the fuse,
// pulses explosion_SCEN once at detonation and shows the plus-shaped blast for a while.
module bomb_controller
    import bomb_controller_pkg::*;
#(
    parameter int FUSE_CYCLES    = 300000000,
    parameter int EXPLODE_CYCLES = 50000000,
    parameter int CNT_W          = 29,
    parameter int MIN_X          = PF_MIN_X,
    parameter int MIN_Y          = PF_MIN_Y
) (
    input  logic              clk,
    input  logic              reset,
    bomb_controller_if.slave  bus
);
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   counter;
    logic [COORD_W-1:0] e_x_r, e_y_r;
    logic               scen_r;
    logic               c_q;
    logic               press, place, fuse_done, blast_done, shape_hit;

    assign press      = bus.C & ~c_q;
    assign place      = (state == IDLE) && press && !bus.game_over;
    assign fuse_done  = (counter == CNT_W'(FUSE_CYCLES - 1));
    assign blast_done = (counter == CNT_W'(EXPLODE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (place)      state_nxt = ARMED;
            ARMED:   if (fuse_done)  state_nxt = EXPLODE;
            EXPLODE: if (blast_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Datapath: counter restarts on every state change; tile latched only on placement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter <= '0;
            e_x_r   <= COORD_W'(MIN_X);
            e_y_r   <= COORD_W'(MIN_Y);
            scen_r  <= 1'b0;
            c_q     <= 1'b1;
        end else begin
            c_q    <= bus.C;
            scen_r <= (state == ARMED) && fuse_done;
            if (state == IDLE || state_nxt != state) counter <= '0;
            else                                     counter <= counter + 1'b1;
            if (place) begin
                e_x_r <= snap(bus.b_x, COORD_W'(MIN_X));
                e_y_r <= snap(bus.b_y, COORD_W'(MIN_Y));
            end
        end
    end

    explosion_shape u_shape (
        .v_x (bus.v_x),
        .v_y (bus.v_y),
        .e_x (e_x_r),
        .e_y (e_y_r),
        .hit (shape_hit)
    );

    always_comb begin
        bus.bomb_active  = (state != IDLE);
        bus.bomb_on      = (state == ARMED)
                        && ({1'b0, bus.v_x} >= {1'b0, e_x_r})
                        && ({1'b0, bus.v_x} <= {1'b0, e_x_r} + (COORD_W+1)'(TILE - 1))
                        && ({1'b0, bus.v_y} >= {1'b0, e_y_r})
                        && ({1'b0, bus.v_y} <= {1'b0, e_y_r} + (COORD_W+1)'(TILE - 1));
        bus.explosion_on = (state == EXPLODE) && shape_hit;
    end

    assign bus.e_x            = e_x_r;
    assign bus.e_y            = e_y_r;
    assign bus.explosion_SCEN = scen_r;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed plus randomized bench for bomb_controller against a time-since-placement model.
module tb_bomb_controller;
    localparam int F     = 10;
    localparam int E     = 5;
    localparam int MIN_X = 143;
    localparam int MIN_Y = 34;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bomb_controller_if bif ();

    bomb_controller #(
        .FUSE_CYCLES(F), .EXPLODE_CYCLES(E), .CNT_W(8), .MIN_X(MIN_X), .MIN_Y(MIN_Y)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif.slave)
    );

    int checks = 0;
    int passed = 0;

    // Model: a bomb is described only by how many cycles ago it was placed.
    bit m_placed = 0;
    int m_t      = 0;
    int m_ex     = MIN_X;
    int m_ey     = MIN_Y;
    bit m_cq     = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic bit m_busy();
        return m_placed && (m_t < F + E);
    endfunction

    task automatic model_edge();
        bit press;
        if (!rst) begin
            m_placed = 0; m_t = 0; m_ex = MIN_X; m_ey = MIN_Y; m_cq = 1;
        end else begin
            press = bif.C && !m_cq;
            m_cq  = bif.C;
            if (!m_busy() && press && !bif.game_over) begin
                m_placed = 1;
                m_t      = 0;
                m_ex     = MIN_X + TILE_FLOOR(int'(bif.b_x) + 8 - MIN_X);
                m_ey     = MIN_Y + TILE_FLOOR(int'(bif.b_y) + 8 - MIN_Y);
            end else if (m_busy()) begin
                m_t++;
            end
        end
    endtask

    function automatic int TILE_FLOOR(input int d);
        return (d / 16) * 16;
    endfunction

    task automatic check_all();
        bit armed, expl, h, v;
        int dx, dy;
        armed = m_placed && m_t < F;
        expl  = m_placed && m_t >= F && m_t < F + E;
        dx    = int'(bif.v_x) - m_ex;
        dy    = int'(bif.v_y) - m_ey;
        h     = dy >= 0 && dy <= 15 && dx >= -48 && dx <= 63;
        v     = dx >= 0 && dx <= 15 && dy >= -48 && dy <= 63;
        check("e_x", 32'(bif.e_x), 32'(m_ex));
        check("e_y", 32'(bif.e_y), 32'(m_ey));
        check("scen", 32'(bif.explosion_SCEN), 32'(m_placed && m_t == F));
        check("active", 32'(bif.bomb_active), 32'(m_busy()));
        check("bomb_on", 32'(bif.bomb_on), 32'(armed && dx >= 0 && dx <= 15 && dy >= 0 && dy <= 15));
        check("expl_on", 32'(bif.explosion_on), 32'(expl && (h || v)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pix(input int vx, input int vy, input bit exp);
        bif.v_x = 10'(vx);
        bif.v_y = 10'(vy);
        #1;
        check($sformatf("pix_%0d_%0d", vx, vy), 32'(bif.explosion_on), 32'(exp));
        check("pix_bomb_off", 32'(bif.bomb_on), 32'd0);
    endtask

    initial begin
        int pulses, first, last_act;
        bif.C = 0; bif.game_over = 0;
        bif.b_x = 150; bif.b_y = 40;
        bif.v_x = 0;   bif.v_y = 0;

        step(); step();
        check("rst_e_x", 32'(bif.e_x), 32'd143);
        check("rst_e_y", 32'(bif.e_y), 32'd34);
        check("rst_active", 32'(bif.bomb_active), 32'd0);
        check("rst_scen", 32'(bif.explosion_SCEN), 32'd0);
        // Button held through reset must not place.
        bif.C = 1; step();
        rst = 1; step(); step();
        check("held_thru_rst", 32'(bif.bomb_active), 32'd0);
        bif.C = 0; step();

        // Placement, snap and fuse timing.
        bif.C = 1; step();
        check("snap1_x", 32'(bif.e_x), 32'd143);
        check("snap1_y", 32'(bif.e_y), 32'd34);
        check("placed_active", 32'(bif.bomb_active), 32'd1);
        bif.C = 0;
        pulses = 0; first = -1; last_act = -1;
        for (int i = 1; i <= F + E + 3; i++) begin
            step();
            if (bif.explosion_SCEN) begin pulses++; if (first < 0) first = i; end
            if (bif.bomb_active) last_act = i;
        end
        check("fuse_delay", 32'(first), 32'(F));
        check("one_pulse", 32'(pulses), 32'd1);
        check("explode_len", 32'(last_act), 32'(F + E - 1));

        // Held button: exactly one bomb.
        bif.C = 1; pulses = 0;
        for (int i = 0; i < 40; i++) begin step(); pulses += int'(bif.explosion_SCEN); end
        check("held_pulses", 32'(pulses), 32'd1);
        bif.C = 0; step();

        // Re-presses while busy are ignored.
        bif.C = 1; step();
        bif.b_x = 300; bif.b_y = 200; pulses = 0;
        for (int i = 0; i < F + E - 2; i++) begin
            bif.C = i[0]; step(); pulses += int'(bif.explosion_SCEN);
        end
        check("repress_e_x", 32'(bif.e_x), 32'd143);
        check("repress_pulses", 32'(pulses), 32'd1);
        bif.C = 0; repeat (4) step();

        // Second snap case.
        bif.b_x = 168; bif.b_y = 55; bif.C = 1; step();
        check("snap2_x", 32'(bif.e_x), 32'd175);
        check("snap2_y", 32'(bif.e_y), 32'd50);
        bif.C = 0; repeat (F + E + 2) step();

        // game_over gating.
        bif.game_over = 1; bif.C = 1; step();
        check("go_blocks", 32'(bif.bomb_active), 32'd0);
        bif.C = 0; bif.game_over = 0; step();
        bif.C = 1; step();
        bif.C = 0; bif.game_over = 1; pulses = 0;
        for (int i = 0; i < F + 2; i++) begin step(); pulses += int'(bif.explosion_SCEN); end
        check("go_armed_detonates", 32'(pulses), 32'd1);
        repeat (E + 2) step();
        bif.game_over = 0;

        // Blast edges at the playfield corner.
        bif.b_x = 150; bif.b_y = 40; bif.C = 1; step();
        bif.C = 0; repeat (F) step();
        pix(95, 40, 1); pix(94, 40, 0); pix(206, 40, 1); pix(207, 40, 0);
        pix(150, 97, 1); pix(159, 40, 1);
        bif.v_x = 0; bif.v_y = 0;
        repeat (E + 2) step();

        // Reset mid-fuse.
        bif.b_x = 300; bif.b_y = 100; bif.C = 1; step();
        bif.C = 0; repeat (5) step();
        rst = 0; step();
        check("midrst_idle", 32'(bif.bomb_active), 32'd0);
        rst = 1; pulses = 0;
        for (int i = 0; i < 20; i++) begin step(); pulses += int'(bif.explosion_SCEN); end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        check("midrst_e_x", 32'(bif.e_x), 32'd143);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bif.C   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) bif.game_over = ~bif.game_over;
            rst     = ($urandom_range(0, 299) != 0);
            bif.b_x = 10'(MIN_X + $urandom_range(0, 480));
            bif.b_y = 10'(MIN_Y + $urandom_range(0, 440));
            bif.v_x = 10'(m_ex - 64 + $urandom_range(0, 143));
            bif.v_y = 10'(m_ey - 64 + $urandom_range(0, 143));
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
